chan_sel_pipe: RTL and testbench
================================

// Module: chan_sel_pipe
// PURPOSE
//  Parametrised N-channel registered data selector with valid/ready handshake.
//  Successor to the 4:1 combinational data selector: width and channel count are
//  generic, the output is registered, and a round-robin scan mode is added next to
//  fixed select. Sits between several producer channels and one downstream consumer.
// PARAMETERS
//  WIDTH     8   data bits per channel
//  CHANNELS  4   number of input channels, >=2
//  SEL_W     localparam = $clog2(CHANNELS); channel index width
// PORTS
//  clk         in   1                 clock, all logic on rising edge
//  rst         in   1                 synchronous, active-high reset
//  din         in   CHANNELS*WIDTH    flat input data; channel k = din[k*WIDTH +: WIDTH]
//  din_valid   in   CHANNELS          per-channel valid
//  din_ready   out  CHANNELS          per-channel ready (combinational, at most one bit high)
//  mode        in   1                 0 = fixed select, 1 = round-robin scan
//  sel_in      in   SEL_W             channel index for fixed mode
//  sel_load    in   1                 1 = capture sel_in into sel_reg
//  dout        out  WIDTH             selected data (registered)
//  dout_ch     out  SEL_W             channel index that produced dout (registered)
//  dout_valid  out  1                 dout/dout_ch valid
//  dout_ready  in   1                 consumer ready
// BEHAVIOUR
//  - Reset: dout=0, dout_ch=0, dout_valid=0, sel_reg=0, rr_ptr=CHANNELS-1. In scan mode
//    channel 0 has first priority after reset. Reset mid-transfer drops the held word.
//  - load_en = ~dout_valid | dout_ready. The output register accepts a new word only
//    when load_en=1. Full throughput: one word per cycle. Latency: 1 cycle from accept.
//  - Grant, fixed mode: g = sel_reg. din_ready[g] = load_en. Other ready bits = 0.
//  - Grant, scan mode: g = first k with din_valid[k]=1, searching rr_ptr+1, rr_ptr+2, ...
//    with wrap from CHANNELS-1 to 0. If no channel is valid, there is no grant and all
//    din_ready bits are 0.
//  - Transfer on channel g when din_valid[g] & din_ready[g]. On the clock edge:
//    dout<=din[g], dout_ch<=g, dout_valid<=1. In scan mode, also rr_ptr<=g.
//  - If load_en=1 and there is no transfer: dout_valid<=0, and dout/dout_ch hold.
//  - If dout_valid=1 and dout_ready=0: dout, dout_ch and dout_valid hold stable.
//    din_ready is all 0.
//  - sel_load=1 with sel_in<CHANNELS: sel_reg<=sel_in, taking effect from the next cycle.
//    The grant in the same cycle uses the old sel_reg. sel_in>=CHANNELS is ignored and
//    sel_reg holds.
//  - A mode change takes effect combinationally in the same cycle. rr_ptr is not
//    altered by the change. A held output word is unaffected.
//  - Non-power-of-two CHANNELS: the wrap and the sel range check both use CHANNELS,
//    not 2**SEL_W.
// CONFIGURATION
//  `define SEL_PARITY_EN adds port dout_par (out, 1).
//    dout_par is registered even parity of the accepted word: dout_par <= ^din[g] on
//    every transfer. It is 0 at reset and holds with dout.
//  Without SEL_PARITY_EN the port and its logic are absent. All other behaviour is
//  identical with and without the macro.
// TESTING
//  1 Fixed mode, WIDTH=8, CHANNELS=4: sel_load=1, sel_in=2; din ch2=8'hA5 valid,
//    dout_ready=1 -> next cycle dout=A5, dout_ch=2, dout_valid=1; din_ready=4'b0100.
//  2 Backpressure: dout_valid=1, dout_ready=0 for 3 cycles, ch2 changes to 8'h3C ->
//    dout holds A5, din_ready=0; release dout_ready -> 3C appears the following cycle.
//  3 Scan mode, all 4 valid, dout_ready=1 -> dout_ch sequence 0,1,2,3,0,...
//    Repeat with only ch1 and ch3 valid -> sequence 1,3,1,3.
//  4 Bad select: sel_in=3'd5 with CHANNELS=5 and sel_load=1 -> sel_reg unchanged.
//    sel_in=4 accepted; ch4 data routed to dout, dout_ch=4.
//  5 Reset mid-stream: assert rst while dout_valid=1 -> next cycle dout_valid=0,
//    dout=0, dout_ch=0; in scan mode, first grant after reset is ch0.
//  6 With SEL_PARITY_EN: din=8'h07 accepted -> dout_par=1; 8'h03 -> dout_par=0.

Source files
------------

// File: rtl/chan_sel_pipe.sv
// N-channel registered data selector with valid/ready handshake, fixed or round-robin grant.
// Optional: define SEL_PARITY_EN to add the registered even-parity output dout_par.
module chan_sel_pipe #(
    parameter int  WIDTH    = 8,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       din_valid,
    output logic [CHANNELS-1:0]       din_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      sel_load,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
`ifdef SEL_PARITY_EN
    output logic                      dout_par,
`endif
    input  logic                      dout_ready
);

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    logic [WIDTH-1:0]    dout_q,       dout_d;
    logic [SEL_W-1:0]    dout_ch_q,    dout_ch_d;
    logic                dout_valid_q, dout_valid_d;
    logic [SEL_W-1:0]    sel_q,        sel_d;
    logic [SEL_W-1:0]    rr_ptr_q,     rr_ptr_d;

    logic                load_en_s;
    logic                grant_vld_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [CHANNELS-1:0] din_ready_s;
    logic                xfer_s;
    logic [WIDTH-1:0]    grant_data_s;
    int                  cand_s;

    // Grant selection: fixed channel, or first valid channel after rr_ptr with wrap at CHANNELS.
    always_comb begin
        load_en_s   = ~dout_valid_q | dout_ready;
        grant_vld_s = 1'b0;
        grant_idx_s = {SEL_W{1'b0}};
        cand_s      = 0;
        if (mode) begin
            for (int i = CHANNELS; i >= 1; i--) begin
                cand_s = int'(rr_ptr_q) + i;
                cand_s = (cand_s >= CHANNELS) ? (cand_s - CHANNELS) : cand_s;
                // Walking offsets downward lets the nearest valid channel win.
                if (din_valid[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = SEL_W'(cand_s);
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end else begin
            grant_vld_s = 1'b1;
            grant_idx_s = sel_q;
        end
    end

    // Ready is one-hot on the granted channel whenever the output register can load.
    always_comb begin
        din_ready_s  = {CHANNELS{1'b0}};
        grant_data_s = din[int'(grant_idx_s)*WIDTH +: WIDTH];
        if (grant_vld_s && load_en_s) begin
            din_ready_s[grant_idx_s] = 1'b1;
        end else begin
            din_ready_s = {CHANNELS{1'b0}};
        end
        xfer_s = grant_vld_s & load_en_s & din_valid[grant_idx_s];
    end

    // Next-state for the output register, round-robin pointer and select register.
    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        if (xfer_s) begin
            dout_d       = grant_data_s;
            dout_ch_d    = grant_idx_s;
            dout_valid_d = 1'b1;
            rr_ptr_d     = mode ? grant_idx_s : rr_ptr_q;
        end else if (load_en_s) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
        if (sel_load && (int'(sel_in) < CHANNELS)) begin
            sel_d = sel_in;
        end else begin
            sel_d = sel_q;
        end
    end

    // State registers with synchronous reset; reset drops any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= {WIDTH{1'b0}};
            dout_ch_q    <= {SEL_W{1'b0}};
            dout_valid_q <= 1'b0;
            sel_q        <= {SEL_W{1'b0}};
            rr_ptr_q     <= SEL_W'(CHANNELS - 1);
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

`ifdef SEL_PARITY_EN
    logic dout_par_q, dout_par_d;

    // Parity of the accepted word, held alongside dout.
    always_comb begin
        if (xfer_s) begin
            dout_par_d = even_parity(grant_data_s);
        end else begin
            dout_par_d = dout_par_q;
        end
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_par_q <= 1'b0;
        end else begin
            dout_par_q <= dout_par_d;
        end
    end

    assign dout_par = dout_par_q;
`endif

    assign din_ready  = din_ready_s;
    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_chan_sel_pipe.sv
// Directed self-checking bench for chan_sel_pipe (CHANNELS=4 and CHANNELS=5 instances).
module tb_chan_sel_pipe;

    logic clk;
    int   n_tests;
    int   n_fail;

    // CHANNELS=4 instance signals
    logic        rst4;
    logic [31:0] din4;
    logic [3:0]  v4;
    logic [3:0]  rdy4;
    logic        mode4;
    logic [1:0]  sel4;
    logic        load4;
    logic [7:0]  dout4;
    logic [1:0]  ch4;
    logic        dv4;
    logic        dr4;
    logic        par4;

    // CHANNELS=5 instance signals
    logic        rst5;
    logic [39:0] din5;
    logic [4:0]  v5;
    logic [4:0]  rdy5;
    logic        mode5;
    logic [2:0]  sel5;
    logic        load5;
    logic [7:0]  dout5;
    logic [2:0]  ch5;
    logic        dv5;
    logic        dr5;
    logic        par5;

    chan_sel_pipe #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
        .clk(clk), .rst(rst4), .din(din4), .din_valid(v4), .din_ready(rdy4),
        .mode(mode4), .sel_in(sel4), .sel_load(load4), .dout(dout4), .dout_ch(ch4),
        .dout_valid(dv4),
`ifdef SEL_PARITY_EN
        .dout_par(par4),
`endif
        .dout_ready(dr4)
    );

    chan_sel_pipe #(.WIDTH(8), .CHANNELS(5)) u_dut5 (
        .clk(clk), .rst(rst5), .din(din5), .din_valid(v5), .din_ready(rdy5),
        .mode(mode5), .sel_in(sel5), .sel_load(load5), .dout(dout5), .dout_ch(ch5),
        .dout_valid(dv5),
`ifdef SEL_PARITY_EN
        .dout_par(par5),
`endif
        .dout_ready(dr5)
    );

`ifndef SEL_PARITY_EN
    assign par4 = 1'b0;
    assign par5 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst4 = 1'b1; din4 = 32'h0; v4 = 4'h0; mode4 = 1'b0; sel4 = 2'd0; load4 = 1'b0; dr4 = 1'b1;
        rst5 = 1'b1; din5 = 40'h0; v5 = 5'h0; mode5 = 1'b0; sel5 = 3'd0; load5 = 1'b0; dr5 = 1'b1;
        tick();
        tick();
        check_val("rst_dout", 32'(dout4), 32'h0);
        check_val("rst_ch", 32'(ch4), 32'h0);
        check_val("rst_valid", 32'(dv4), 32'h0);
        rst4 = 1'b0;
        rst5 = 1'b0;

        // Fixed mode: load sel=2; same-cycle grant still uses old sel 0
        load4 = 1'b1; sel4 = 2'd2; din4[23:16] = 8'hA5; v4 = 4'b0100;
        settle();
        check_val("old_sel_ready", 32'(rdy4), 32'h1);
        tick();
        load4 = 1'b0;
        settle();
        check_val("fix_ready", 32'(rdy4), 32'h4);
        tick();
        check_val("fix_dout", 32'(dout4), 32'hA5);
        check_val("fix_ch", 32'(ch4), 32'h2);
        check_val("fix_valid", 32'(dv4), 32'h1);

        // Backpressure holds the word and withdraws ready
        dr4 = 1'b0; din4[23:16] = 8'h3C;
        settle();
        check_val("bp_ready", 32'(rdy4), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("bp_dout", 32'(dout4), 32'hA5);
            check_val("bp_valid", 32'(dv4), 32'h1);
        end
        dr4 = 1'b1;
        settle();
        check_val("rel_ready", 32'(rdy4), 32'h4);
        tick();
        check_val("rel_dout", 32'(dout4), 32'h3C);
        v4 = 4'b0000;
        tick();
        check_val("idle_valid", 32'(dv4), 32'h0);
        check_val("idle_dout", 32'(dout4), 32'h3C);

        // Scan mode, all valid: 0,1,2,3,0
        mode4 = 1'b1; v4 = 4'b1111; din4 = 32'h13121110;
        settle();
        check_val("scan_ready0", 32'(rdy4), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("scan_all_ch", 32'(ch4), 32'(i % 4));
            check_val("scan_all_dout", 32'(dout4), 32'(8'h10 + 8'(i % 4)));
        end
        // Only ch1 and ch3 valid: 1,3,1,3
        v4 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("scan_13_ch", 32'(ch4), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        v4 = 4'b0010;
        tick();
        check_val("scan_pre_rst_ch", 32'(ch4), 32'd1);

        // Reset mid-stream drops the word; first scan grant is ch0
        rst4 = 1'b1; v4 = 4'b1111;
        tick();
        check_val("mrst_valid", 32'(dv4), 32'h0);
        check_val("mrst_dout", 32'(dout4), 32'h0);
        check_val("mrst_ch", 32'(ch4), 32'h0);
        check_val("mrst_par", 32'(par4), 32'h0);
        rst4 = 1'b0;
        settle();
        check_val("mrst_ready", 32'(rdy4), 32'h1);
        tick();
        check_val("mrst_first_ch", 32'(ch4), 32'h0);
        check_val("mrst_first_dout", 32'(dout4), 32'h10);

`ifdef SEL_PARITY_EN
        mode4 = 1'b0; v4 = 4'b0001; din4[7:0] = 8'h07;
        tick();
        check_val("par_07", 32'(par4), 32'h1);
        din4[7:0] = 8'h03;
        tick();
        check_val("par_03", 32'(par4), 32'h0);
        check_val("par_dout", 32'(dout4), 32'h03);
`endif

        // CHANNELS=5: out-of-range select ignored, sel 4 accepted
        load5 = 1'b1; sel5 = 3'd5;
        tick();
        load5 = 1'b0; v5 = 5'b00001; din5[7:0] = 8'h50;
        settle();
        check_val("bad_sel_ready", 32'(rdy5), 32'h01);
        tick();
        check_val("bad_sel_ch", 32'(ch5), 32'h0);
        check_val("bad_sel_dout", 32'(dout5), 32'h50);
        load5 = 1'b1; sel5 = 3'd4; v5 = 5'b00000;
        tick();
        load5 = 1'b0; v5 = 5'b10000; din5[39:32] = 8'h44;
        settle();
        check_val("sel4_ready", 32'(rdy5), 32'h10);
        tick();
        check_val("sel4_dout", 32'(dout5), 32'h44);
        check_val("sel4_ch", 32'(ch5), 32'h4);

        // Scan wrap at 5 channels: rr_ptr starts at 4 -> 0,4,0
        mode5 = 1'b1; v5 = 5'b10001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("wrap5_ch", 32'(ch5), (i % 2 == 0) ? 32'd0 : 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
